// File: rtl/serial_add_seq.sv
// Bit-serial adder: one shared full-adder cell sums two WIDTH-bit operands LSB first over WIDTH cycles.
// Operands are captured on start in IDLE; sum/cout are loaded on the RUN->DONE edge and held.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic             cr_q, cr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_sum, fa_cout;
  logic [WIDTH-1:0] ps_shift;

  Full_Adder u_fa (
    .a_i    (sa_q[0]),
    .b_i    (sb_q[0]),
    .c_i    (cr_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  // New bit enters at the MSB; after WIDTH shifts bit 0 of the result sits at ps[0].
  assign ps_shift = WIDTH'({fa_sum, ps_q} >> 1);

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ps_d    = ps_q;
    cr_d    = cr_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          cr_d    = cin;
          ps_d    = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        ps_d  = ps_shift;
        cr_d  = fa_cout;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = ps_shift;
          cout_d  = fa_cout;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ps_q    <= '0;
      cr_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ps_q    <= ps_d;
      cr_q    <= cr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

module Full_Adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i ^ c_i;
  assign cout_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq at WIDTH=8 and WIDTH=1: per-cycle cycle-accurate model plus a result scoreboard.
module tb_serial_add_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1 = 1'b0, cin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int total = 0, passed = 0, cyc = 0;
  int m8_st = 0, m8_cnt = 0, m1_st = 0, m1_cnt = 0;
  bit m8_new = 0, m1_new = 0;
  logic [8:0] q8[$];
  logic [1:0] q1[$];
  logic [8:0] m8_res = '0;
  logic [1:0] m1_res = '0;
  int done8_cnt = 0, done1_cnt = 0, last_done = -1, gap_min = 1000, gap_max = 0;
  int d0, d1;

  serial_add_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_seq #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Model state is sampled at the same edge the DUT samples its inputs.
  task automatic step_models();
    m8_new = 0;
    m1_new = 0;
    if (rst) begin
      m8_st = 0; m1_st = 0;
      q8.delete(); q1.delete();
      m8_res = '0; m1_res = '0;
    end else begin
      case (m8_st)
        0: if (start8) begin
             q8.push_back({1'b0, a8} + {1'b0, b8} + {8'd0, cin8});
             m8_st = 1; m8_cnt = 0;
           end
        1: begin m8_cnt++; if (m8_cnt == 8) begin m8_st = 2; m8_new = 1; end end
        default: m8_st = 0;
      endcase
      case (m1_st)
        0: if (start1) begin
             q1.push_back({1'b0, a1} + {1'b0, b1} + {1'b0, cin1});
             m1_st = 1; m1_cnt = 0;
           end
        1: begin m1_cnt++; if (m1_cnt == 1) begin m1_st = 2; m1_new = 1; end end
        default: m1_st = 0;
      endcase
    end
  endtask

  task automatic check_outputs();
    if (m8_new) begin
      chk("sb8_pending", 64'(q8.size() > 0), 1);
      if (q8.size() > 0) m8_res = q8.pop_front();
    end
    if (m1_new) begin
      chk("sb1_pending", 64'(q1.size() > 0), 1);
      if (q1.size() > 0) m1_res = q1.pop_front();
    end
    chk("busy8", busy8, m8_st == 1);
    chk("done8", done8, m8_st == 2);
    chk("res8", {cout8, sum8}, m8_res);
    chk("busy1", busy1, m1_st == 1);
    chk("done1", done1, m1_st == 2);
    chk("res1", {cout1, sum1}, m1_res);
    if (done8 === 1'b1) begin
      done8_cnt++;
      if (last_done >= 0) begin
        if (cyc - last_done < gap_min) gap_min = cyc - last_done;
        if (cyc - last_done > gap_max) gap_max = cyc - last_done;
      end
      last_done = cyc;
    end
    if (done1 === 1'b1) done1_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    step_models();
    #1;
    check_outputs();
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_sum8", sum8, 0);
    chk("rst_cout8", cout8, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    rst = 1'b0;
    tick();

    // Directed additions
    op8(8'h5A, 8'h3C, 1'b0);
    chk("add_5a_3c", {cout8, sum8}, 9'h096);
    op8(8'hFF, 8'h01, 1'b0);
    chk("add_ff_01", {cout8, sum8}, 9'h100);
    op8(8'hFF, 8'h00, 1'b1);
    chk("add_ff_00_c", {cout8, sum8}, 9'h100);
    op8(8'h80, 8'h80, 1'b1);
    chk("add_80_80_c", {cout8, sum8}, 9'h101);

    // Start and operand changes during RUN/DONE are ignored
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    tick();
    d0 = done8_cnt;
    a8 = 8'hFF; b8 = 8'hFF;
    tick();
    for (int i = 0; i < 8; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      tick();
    end
    start8 = 1'b0;
    repeat (4) tick();
    chk("ign_one_done", done8_cnt - d0, 1);
    chk("ign_sum", {cout8, sum8}, 9'h030);

    // Asynchronous reset in the middle of RUN
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    chk("pre_rst_busy", busy8, 1);
    #2;
    rst = 1'b1;
    #1;
    m8_st = 0; m1_st = 0; q8.delete(); q1.delete(); m8_res = '0; m1_res = '0;
    chk("arst_busy", busy8, 0);
    chk("arst_done", done8, 0);
    chk("arst_sum", sum8, 0);
    chk("arst_cout", cout8, 0);
    d0 = done8_cnt;
    tick();
    rst = 1'b0;
    repeat (12) tick();
    chk("arst_no_done", done8_cnt - d0, 0);
    op8(8'h01, 8'h02, 1'b0);
    chk("post_rst_add", {cout8, sum8}, 9'h003);

    // Back-to-back with start held high
    gap_min = 1000; gap_max = 0; last_done = -1;
    d0 = done8_cnt;
    start8 = 1'b1;
    for (int i = 0; i < 52; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      tick();
    end
    start8 = 1'b0;
    repeat (12) tick();
    chk("b2b_dones", done8_cnt - d0, 6);
    chk("b2b_gap_min", gap_min, 10);
    chk("b2b_gap_max", gap_max, 10);

    // Random operands on both widths
    d0 = done8_cnt;
    d1 = done1_cnt;
    for (int i = 0; i < 200; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      start8 = 1'b1; start1 = 1'b1;
      tick();
      start8 = 1'b0; start1 = 1'b0;
      repeat (10) tick();
    end
    chk("rand8_dones", done8_cnt - d0, 200);
    chk("rand1_dones", done1_cnt - d1, 200);
    chk("sb8_drained", q8.size(), 0);
    chk("sb1_drained", q1.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
